// File: rtl/kilit_pkg.sv
// Shared types and helpers for the multi-lock combination controller.
package kilit_pkg;

    typedef enum logic [1:0] {
        BEKLE = 2'd0,
        GIRIS = 2'd1,
        ACIK  = 2'd2,
        CEZA  = 2'd3
    } kilit_durum_t;

    // Bit offset of step `adim` of lock `kilit` inside the packed code vector.
    function automatic int unsigned adim_ofset(
        input int unsigned kilit,
        input int unsigned adim,
        input int unsigned adim_sayisi,
        input int unsigned adim_w
    );
        return (kilit * adim_sayisi + adim) * (adim_w + 1);
    endfunction

endpackage

// File: rtl/tek_kilit_fsm.sv
// One combination lock: step entry, error counting, penalty and open timer.
// ACIK_ZAMAN_ASIMI_EN enables auto-relock of an open lock after ACIK_SURESI cycles.
module tek_kilit_fsm
    import kilit_pkg::*;
#(
    parameter int unsigned ADIM_SAYISI = 2,
    parameter int unsigned ADIM_W      = 3,
    parameter int unsigned HATA_LIMIT  = 3,
    parameter int unsigned CEZA_SURESI = 16,
    parameter int unsigned ACIK_SURESI = 32
) (
    input  logic                              clk,
    input  logic                              i_rst,
    input  logic                              i_temizle,
    input  logic                              i_kapat,
    input  logic                              i_adim_kabul,
    input  logic                              i_adim_yon,
    input  logic [ADIM_W-1:0]                 i_adim_deger,
    input  logic [ADIM_SAYISI*(ADIM_W+1)-1:0] i_sifre,
    output logic                              o_hazir_c,
    output logic                              o_acik_d_c,
    output logic                              o_hata_d_c,
    output logic                              o_acik,
    output logic                              o_ceza
);

    localparam int unsigned ADIM_GEN  = ADIM_W + 1;
    localparam int unsigned IDX_W     = (ADIM_SAYISI > 1) ? $clog2(ADIM_SAYISI) : 1;
    localparam int unsigned SAY_W     = $clog2(HATA_LIMIT + 1);
    localparam int unsigned ZAMAN_UST = (CEZA_SURESI > ACIK_SURESI) ? CEZA_SURESI : ACIK_SURESI;
    localparam int unsigned ZAMAN_W   = (ZAMAN_UST > 1) ? $clog2(ZAMAN_UST) : 1;

    kilit_durum_t        r_durum, w_durum_d;
    logic [IDX_W-1:0]    r_idx, w_idx_d, w_idx_c;
    logic                r_hatali, w_hatali_d, w_hatali_c;
    logic [SAY_W-1:0]    r_hata_say, w_hata_say_d;
    logic [ZAMAN_W-1:0]  r_zaman, w_zaman_d;
    logic                w_hata_d, w_ceza_d;
    logic [ADIM_GEN-1:0] w_beklenen;

    // An idle lock always compares against step 0; the mismatch flag is sticky within an attempt.
    assign w_idx_c    = (r_durum == GIRIS) ? r_idx : '0;
    assign w_beklenen = i_sifre[adim_ofset(0, 32'(w_idx_c), ADIM_SAYISI, ADIM_W) +: ADIM_GEN];
    assign w_hatali_c = ((r_durum == GIRIS) && r_hatali) ||
                        (w_beklenen != {i_adim_yon, i_adim_deger});

    // State register; outputs are registered from their next values.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_durum    <= BEKLE;
            r_idx      <= '0;
            r_hatali   <= 1'b0;
            r_hata_say <= '0;
            r_zaman    <= '0;
            o_acik     <= 1'b0;
            o_ceza     <= 1'b0;
        end else begin
            r_durum    <= w_durum_d;
            r_idx      <= w_idx_d;
            r_hatali   <= w_hatali_d;
            r_hata_say <= w_hata_say_d;
            r_zaman    <= w_zaman_d;
            o_acik     <= o_acik_d_c;
            o_ceza     <= w_ceza_d;
        end
    end

    // Next-state logic: code load > relock > step.
    always_comb begin
        w_durum_d    = r_durum;
        w_idx_d      = r_idx;
        w_hatali_d   = r_hatali;
        w_hata_say_d = r_hata_say;
        w_zaman_d    = r_zaman;
        w_hata_d     = 1'b0;
        if (i_temizle) begin
            w_durum_d    = BEKLE;
            w_idx_d      = '0;
            w_hatali_d   = 1'b0;
            w_hata_say_d = '0;
            w_zaman_d    = '0;
        end else begin
            case (r_durum)
                BEKLE, GIRIS: begin
                    if (i_kapat) begin
                        w_durum_d  = BEKLE;
                        w_idx_d    = '0;
                        w_hatali_d = 1'b0;
                    end else if (i_adim_kabul) begin
                        if (w_idx_c == IDX_W'(ADIM_SAYISI - 1)) begin
                            w_idx_d    = '0;
                            w_hatali_d = 1'b0;
                            w_zaman_d  = '0;
                            if (!w_hatali_c) begin
                                w_durum_d    = ACIK;
                                w_hata_say_d = '0;
                            end else begin
                                w_hata_d = 1'b1;
                                if (r_hata_say == SAY_W'(HATA_LIMIT - 1)) begin
                                    w_durum_d    = CEZA;
                                    w_hata_say_d = SAY_W'(HATA_LIMIT);
                                end else begin
                                    w_durum_d    = BEKLE;
                                    w_hata_say_d = r_hata_say + SAY_W'(1);
                                end
                            end
                        end else begin
                            w_durum_d  = GIRIS;
                            w_idx_d    = w_idx_c + IDX_W'(1);
                            w_hatali_d = w_hatali_c;
                        end
                    end
                end
                ACIK: begin
                    if (i_kapat) begin
                        w_durum_d = BEKLE;
                    end
`ifdef ACIK_ZAMAN_ASIMI_EN
                    else if (r_zaman == ZAMAN_W'(ACIK_SURESI - 1)) begin
                        w_durum_d = BEKLE;
                        w_zaman_d = '0;
                    end else begin
                        w_zaman_d = r_zaman + ZAMAN_W'(1);
                    end
`endif
                end
                CEZA: begin
                    if (r_zaman == ZAMAN_W'(CEZA_SURESI - 1)) begin
                        w_durum_d    = BEKLE;
                        w_hata_say_d = '0;
                        w_zaman_d    = '0;
                    end else begin
                        w_zaman_d = r_zaman + ZAMAN_W'(1);
                    end
                end
                default: w_durum_d = BEKLE;
            endcase
        end
    end

    // Output decode.
    always_comb begin
        o_hazir_c  = (r_durum == BEKLE) || (r_durum == GIRIS);
        o_acik_d_c = (w_durum_d == ACIK);
        o_hata_d_c = w_hata_d;
        w_ceza_d   = (w_durum_d == CEZA);
    end

endmodule

// File: rtl/coklu_kilit_denetleyici.sv
// Multi-lock combination controller: code registers, step handshake and lock array.
// ACIK_ZAMAN_ASIMI_EN enables auto-relock of open locks (see tek_kilit_fsm).
module coklu_kilit_denetleyici
    import kilit_pkg::*;
#(
    parameter int unsigned KILIT_SAYISI = 2,
    parameter int unsigned ADIM_SAYISI  = 2,
    parameter int unsigned ADIM_W       = 3,
    parameter int unsigned HATA_LIMIT   = 3,
    parameter int unsigned CEZA_SURESI  = 16,
    parameter int unsigned ACIK_SURESI  = 32
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           sifre_yukle,
    input  logic [KILIT_SAYISI*ADIM_SAYISI*(ADIM_W+1)-1:0] kilit_sifreler,
    input  logic                                           adim_gecerli,
    output logic                                           adim_hazir,
    input  logic [((KILIT_SAYISI > 1) ? $clog2(KILIT_SAYISI) : 1)-1:0] kilit_sec,
    input  logic                                           adim_yon,
    input  logic [ADIM_W-1:0]                              adim_deger,
    input  logic                                           kapat,
    output logic [KILIT_SAYISI-1:0]                        kilit_acik,
    output logic [KILIT_SAYISI-1:0]                        kilit_ceza,
    output logic                                           kilitler_acik,
    output logic                                           hata
);

    localparam int unsigned SEC_W   = (KILIT_SAYISI > 1) ? $clog2(KILIT_SAYISI) : 1;
    localparam int unsigned KILIT_B = ADIM_SAYISI * (ADIM_W + 1);
    localparam int unsigned SIFRE_W = KILIT_SAYISI * KILIT_B;

    logic [SIFRE_W-1:0]      r_sifre;
    logic                    r_hata, r_hepsi;
    logic [KILIT_SAYISI-1:0] w_sec, w_hazir, w_acik_d, w_hata_d;
    logic                    w_kabul;

    // An out-of-range kilit_sec matches no lock, so the step is never ready.
    assign adim_hazir    = (|(w_hazir & w_sec)) && !sifre_yukle;
    assign w_kabul       = adim_gecerli && adim_hazir;
    assign hata          = r_hata;
    assign kilitler_acik = r_hepsi;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sifre <= '0;
            r_hata  <= 1'b0;
            r_hepsi <= 1'b0;
        end else begin
            if (sifre_yukle) begin
                r_sifre <= kilit_sifreler;
            end
            r_hata  <= |w_hata_d;
            r_hepsi <= &w_acik_d;
        end
    end

    for (genvar k = 0; k < KILIT_SAYISI; k++) begin : g_kilit
        assign w_sec[k] = (kilit_sec == SEC_W'(k));

        tek_kilit_fsm #(
            .ADIM_SAYISI (ADIM_SAYISI),
            .ADIM_W      (ADIM_W),
            .HATA_LIMIT  (HATA_LIMIT),
            .CEZA_SURESI (CEZA_SURESI),
            .ACIK_SURESI (ACIK_SURESI)
        ) u_kilit (
            .clk          (clk),
            .i_rst        (rst),
            .i_temizle    (sifre_yukle),
            .i_kapat      (kapat),
            .i_adim_kabul (w_kabul && w_sec[k]),
            .i_adim_yon   (adim_yon),
            .i_adim_deger (adim_deger),
            .i_sifre      (r_sifre[adim_ofset(k, 0, ADIM_SAYISI, ADIM_W) +: KILIT_B]),
            .o_hazir_c    (w_hazir[k]),
            .o_acik_d_c   (w_acik_d[k]),
            .o_hata_d_c   (w_hata_d[k]),
            .o_acik       (kilit_acik[k]),
            .o_ceza       (kilit_ceza[k])
        );
    end

endmodule

// File: tb/tb_coklu_kilit_denetleyici.sv
// Bench for coklu_kilit_denetleyici: directed scenarios plus randomized run against a
// sequence-level lock model. Define ACIK_ZAMAN_ASIMI_EN to match an auto-relock build.
module tb_coklu_kilit_denetleyici;

    localparam int KS = 2;
    localparam int AS = 2;
    localparam int AW = 3;
    localparam int AG = AW + 1;
    localparam int HATA_LIMIT  = 3;
    localparam int CEZA_SURESI = 16;
    localparam int ACIK_SURESI = 32;
    localparam int SEC_W = 1;
    localparam int KOD_W = KS * AS * AG;

    logic             clk, rst, sifre_yukle, adim_gecerli, adim_hazir, adim_yon, kapat;
    logic [KOD_W-1:0] kilit_sifreler;
    logic [SEC_W-1:0] kilit_sec;
    logic [AW-1:0]    adim_deger;
    logic [KS-1:0]    kilit_acik, kilit_ceza;
    logic             kilitler_acik, hata;

    int n_kontrol = 0;
    int n_hata    = 0;

    // Model: codes, partially entered sequence, open flag, penalty/open cycles left.
    logic [AG-1:0] m_kod[KS][AS];
    logic [AG-1:0] m_giris[KS][AS];
    int            m_adet[KS];
    bit            m_acik[KS];
    int            m_acik_kalan[KS];
    int            m_ceza[KS];
    int            m_hata_say[KS];
    bit            m_hata;

    coklu_kilit_denetleyici dut (
        .clk            (clk),
        .rst            (rst),
        .sifre_yukle    (sifre_yukle),
        .kilit_sifreler (kilit_sifreler),
        .adim_gecerli   (adim_gecerli),
        .adim_hazir     (adim_hazir),
        .kilit_sec      (kilit_sec),
        .adim_yon       (adim_yon),
        .adim_deger     (adim_deger),
        .kapat          (kapat),
        .kilit_acik     (kilit_acik),
        .kilit_ceza     (kilit_ceza),
        .kilitler_acik  (kilitler_acik),
        .hata           (hata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic m_hazir();
        int s = int'(kilit_sec);
        if (sifre_yukle || s >= KS) return 1'b0;
        return !m_acik[s] && (m_ceza[s] == 0);
    endfunction

    function automatic logic [KS-1:0] m_acik_v();
        logic [KS-1:0] v;
        for (int k = 0; k < KS; k++) v[k] = m_acik[k];
        return v;
    endfunction

    function automatic logic [KS-1:0] m_ceza_v();
        logic [KS-1:0] v;
        for (int k = 0; k < KS; k++) v[k] = (m_ceza[k] > 0);
        return v;
    endfunction

    task automatic m_temizle(input int k);
        m_adet[k] = 0; m_acik[k] = 0; m_acik_kalan[k] = 0; m_ceza[k] = 0; m_hata_say[k] = 0;
    endtask

    // Applies one clock edge of the specified behaviour to the model.
    task automatic model_guncelle();
        int  s = int'(kilit_sec);
        bit  kabul = adim_gecerli && m_hazir();
        bit  dogru;
        m_hata = 1'b0;
        if (rst) begin
            for (int k = 0; k < KS; k++) begin
                for (int i = 0; i < AS; i++) m_kod[k][i] = '0;
                m_temizle(k);
            end
        end else if (sifre_yukle) begin
            for (int k = 0; k < KS; k++) begin
                for (int i = 0; i < AS; i++) m_kod[k][i] = kilit_sifreler[(k*AS+i)*AG +: AG];
                m_temizle(k);
            end
        end else begin
            for (int k = 0; k < KS; k++) begin
                if (m_ceza[k] > 0) begin
                    m_ceza[k]--;
                    if (m_ceza[k] == 0) m_hata_say[k] = 0;
                end else if (m_acik[k]) begin
                    if (kapat) m_acik[k] = 0;
`ifdef ACIK_ZAMAN_ASIMI_EN
                    else begin
                        m_acik_kalan[k]--;
                        if (m_acik_kalan[k] == 0) m_acik[k] = 0;
                    end
`endif
                end else if (kapat) begin
                    m_adet[k] = 0;
                end else if (kabul && s == k) begin
                    m_giris[k][m_adet[k]] = {adim_yon, adim_deger};
                    m_adet[k]++;
                    if (m_adet[k] == AS) begin
                        dogru = 1;
                        for (int i = 0; i < AS; i++) if (m_giris[k][i] != m_kod[k][i]) dogru = 0;
                        m_adet[k] = 0;
                        if (dogru) begin
                            m_acik[k] = 1; m_acik_kalan[k] = ACIK_SURESI; m_hata_say[k] = 0;
                        end else begin
                            m_hata = 1; m_hata_say[k]++;
                            if (m_hata_say[k] == HATA_LIMIT) m_ceza[k] = CEZA_SURESI;
                        end
                    end
                end
            end
        end
    endtask

    task automatic ilerle();
        model_guncelle();
        @(posedge clk);
        #1;
    endtask

    task automatic adim(input int k, input logic yon, input int deger);
        adim_gecerli = 1'b1;
        kilit_sec    = SEC_W'(k);
        adim_yon     = yon;
        adim_deger   = AW'(deger);
        ilerle();
        adim_gecerli = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; sifre_yukle = 1'b0; adim_gecerli = 1'b0; kapat = 1'b0;
        kilit_sec = '0; adim_yon = 1'b0; adim_deger = '0; kilit_sifreler = '0;
        ilerle(); ilerle();
        n_kontrol++;
        if ({kilit_acik, kilit_ceza, kilitler_acik, hata} !== '0) begin
            n_hata++;
            $display("FAIL reset_outputs: got acik=%b ceza=%b hepsi=%b hata=%b, want all 0",
                     kilit_acik, kilit_ceza, kilitler_acik, hata);
        end
        rst = 1'b0;
        #1;
        n_kontrol++;
        if (adim_hazir !== 1'b1) begin
            n_hata++; $display("FAIL reset_hazir: got %b want 1", adim_hazir);
        end
    endtask

    task automatic test_acma();
        sifre_yukle = 1'b1; kilit_sifreler = KOD_W'(16'h1B2D);
        ilerle();
        sifre_yukle = 1'b0;
        adim(0, 1'b1, 5); adim(0, 1'b0, 2);
        n_kontrol++;
        if (kilit_acik !== 2'b01 || kilitler_acik !== 1'b0 || hata !== 1'b0) begin
            n_hata++;
            $display("FAIL open_lock0: got acik=%b hepsi=%b hata=%b want 01/0/0", kilit_acik, kilitler_acik, hata);
        end
        adim(1, 1'b1, 3); adim(1, 1'b0, 1);
        n_kontrol++;
        if (kilit_acik !== 2'b11 || kilitler_acik !== 1'b1) begin
            n_hata++;
            $display("FAIL open_both: got acik=%b hepsi=%b want 11/1", kilit_acik, kilitler_acik);
        end
        kapat = 1'b1; ilerle(); kapat = 1'b0;
        n_kontrol++;
        if (kilit_acik !== 2'b00 || kilitler_acik !== 1'b0) begin
            n_hata++;
            $display("FAIL kapat_all: got acik=%b hepsi=%b want 00/0", kilit_acik, kilitler_acik);
        end
    endtask

    task automatic test_ceza();
        int n = 0;
        bit hazir_hatali = 0;
        for (int a = 0; a < HATA_LIMIT; a++) begin
            adim(0, 1'b1, 5);
            n_kontrol++;
            if (hata !== 1'b0) begin n_hata++; $display("FAIL ceza_ilk_adim: got hata=%b want 0", hata); end
            adim(0, 1'b0, 3);
            n_kontrol++;
            if (hata !== 1'b1) begin n_hata++; $display("FAIL ceza_hata_pulse%0d: got %b want 1", a, hata); end
            n_kontrol++;
            if (kilit_ceza[0] !== (a == HATA_LIMIT - 1)) begin
                n_hata++; $display("FAIL ceza_giris%0d: got ceza=%b want %b", a, kilit_ceza[0], a == HATA_LIMIT - 1);
            end
        end
        kilit_sec = '0;
        while (kilit_ceza[0] === 1'b1 && n < 100) begin
            #1;
            if (adim_hazir !== 1'b0) hazir_hatali = 1;
            ilerle();
            n++;
        end
        n_kontrol++;
        if (n != CEZA_SURESI) begin n_hata++; $display("FAIL ceza_sure: got %0d cycles want %0d", n, CEZA_SURESI); end
        n_kontrol++;
        if (hazir_hatali) begin n_hata++; $display("FAIL ceza_hazir: got hazir=1 during penalty want 0"); end
        adim(0, 1'b1, 5); adim(0, 1'b0, 2);
        n_kontrol++;
        if (kilit_acik !== 2'b01) begin n_hata++; $display("FAIL ceza_sonra_acma: got %b want 01", kilit_acik); end
        kapat = 1'b1; ilerle(); kapat = 1'b0;
    endtask

    task automatic test_kapat_iptal();
        adim(0, 1'b1, 5);
        kapat = 1'b1; ilerle(); kapat = 1'b0;
        n_kontrol++;
        if (hata !== 1'b0 || kilit_acik !== 2'b00) begin
            n_hata++; $display("FAIL kapat_iptal: got hata=%b acik=%b want 0/00", hata, kilit_acik);
        end
        // A step coinciding with kapat is dropped, so (0,2) then starts a fresh, wrong attempt.
        kapat = 1'b1; adim(0, 1'b1, 5); kapat = 1'b0;
        adim(0, 1'b0, 2);
        n_kontrol++;
        if (kilit_acik !== 2'b00) begin n_hata++; $display("FAIL kapat_ayni_cevrim: got acik=%b want 00", kilit_acik); end
        kapat = 1'b1; ilerle(); kapat = 1'b0;
        adim(0, 1'b1, 5); adim(0, 1'b0, 2);
        n_kontrol++;
        if (kilit_acik !== 2'b01) begin n_hata++; $display("FAIL kapat_sonra_acma: got %b want 01", kilit_acik); end
        kapat = 1'b1; ilerle(); kapat = 1'b0;
    endtask

    task automatic test_back_to_back();
        adim(0, 1'b1, 5); adim(1, 1'b1, 3); adim(0, 1'b0, 2);
        n_kontrol++;
        if (kilit_acik !== 2'b01) begin n_hata++; $display("FAIL interleave_lock0: got %b want 01", kilit_acik); end
        adim(1, 1'b0, 1);
        n_kontrol++;
        if (kilit_acik !== 2'b11 || kilitler_acik !== 1'b1) begin
            n_hata++; $display("FAIL interleave_both: got acik=%b hepsi=%b want 11/1", kilit_acik, kilitler_acik);
        end
        kapat = 1'b1; ilerle(); kapat = 1'b0;
    endtask

    task automatic test_rst_orta();
        adim(0, 1'b1, 5);
        rst = 1'b1; ilerle(); rst = 1'b0;
        n_kontrol++;
        if ({kilit_acik, kilit_ceza, kilitler_acik, hata} !== '0) begin
            n_hata++; $display("FAIL rst_orta_outputs: got acik=%b ceza=%b want 0", kilit_acik, kilit_ceza);
        end
        adim(0, 1'b0, 0); adim(0, 1'b0, 0);
        n_kontrol++;
        if (kilit_acik !== 2'b01) begin n_hata++; $display("FAIL rst_sifir_kod: got %b want 01", kilit_acik); end
    endtask

    task automatic test_zaman_asimi();
        int n = 0;
        kapat = 1'b1; ilerle(); kapat = 1'b0;
        adim(0, 1'b0, 0); adim(0, 1'b0, 0);
`ifdef ACIK_ZAMAN_ASIMI_EN
        while (kilit_acik[0] === 1'b1 && n < 100) begin ilerle(); n++; end
        n_kontrol++;
        if (n != ACIK_SURESI) begin n_hata++; $display("FAIL acik_zaman: got %0d cycles want %0d", n, ACIK_SURESI); end
`else
        while (kilit_acik[0] === 1'b1 && n < ACIK_SURESI + 8) begin ilerle(); n++; end
        n_kontrol++;
        if (n != ACIK_SURESI + 8) begin n_hata++; $display("FAIL acik_tutma: closed after %0d cycles want held", n); end
`endif
        kapat = 1'b1; ilerle(); kapat = 1'b0;
    endtask

    task automatic test_random();
        int s;
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 499) == 0);
            sifre_yukle  = ($urandom_range(0, 99) == 0);
            if (sifre_yukle) kilit_sifreler = KOD_W'($urandom);
            kapat        = ($urandom_range(0, 29) == 0);
            adim_gecerli = ($urandom_range(0, 9) < 7);
            kilit_sec    = SEC_W'($urandom_range(0, KS - 1));
            s = int'(kilit_sec);
            if ($urandom_range(0, 3) != 0 && m_adet[s] < AS) {adim_yon, adim_deger} = m_kod[s][m_adet[s]];
            else {adim_yon, adim_deger} = AG'($urandom);
            #1;
            n_kontrol++;
            if (adim_hazir !== m_hazir()) begin
                n_hata++; $display("FAIL rnd_hazir c=%0d: got %b want %b", c, adim_hazir, m_hazir());
            end
            ilerle();
            n_kontrol++;
            if (kilit_acik !== m_acik_v() || kilit_ceza !== m_ceza_v() ||
                kilitler_acik !== (&m_acik_v()) || hata !== m_hata) begin
                n_hata++;
                $display("FAIL rnd_out c=%0d: got acik=%b ceza=%b hepsi=%b hata=%b want %b/%b/%b/%b", c,
                         kilit_acik, kilit_ceza, kilitler_acik, hata, m_acik_v(), m_ceza_v(), &m_acik_v(), m_hata);
            end
        end
        rst = 1'b0; sifre_yukle = 1'b0; kapat = 1'b0; adim_gecerli = 1'b0;
    endtask

    initial begin
        test_reset();
        test_acma();
        test_ceza();
        test_kapat_iptal();
        test_back_to_back();
        test_rst_orta();
        test_zaman_asimi();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_kontrol, n_hata);
        $finish;
    end

endmodule
